debug_uart_tx_arbiter: RTL

// - Shares the single OCD UART transmitter between NUM_REQ frame-level requesters.

---
 rtl/debug_uart_arb_pkg.sv | 18 +
 rtl/debug_rr_pick.sv | 36 +++
 rtl/debug_uart_tx_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/debug_uart_arb_pkg.sv
// Shared types and constants for the debug UART transmit arbiter.
// The index type is sized for the largest supported requester count (8).
package debug_uart_arb_pkg;

    localparam int MAX_NUM_REQ   = 8;
    localparam int REQ_IDX_W     = $clog2(MAX_NUM_REQ);
    localparam int TIMEOUT_CNT_W = 17;

    typedef logic [REQ_IDX_W-1:0] req_idx_t;

    typedef enum logic [3:0] {
        S_IDLE    = 4'b0001,
        S_OWNED   = 4'b0010,
        S_BUSY    = 4'b0100,
        S_RELEASE = 4'b1000
    } state_t;

endpackage

// File: rtl/debug_rr_pick.sv
// Combinational round-robin picker: searches req starting at ptr+1 (wrapping)
// and returns the first requester as a one-hot vector and as an index.
module debug_rr_pick
    import debug_uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  req_idx_t           ptr,
    output logic [NUM_REQ-1:0] winner,
    output req_idx_t           win_idx,
    output logic               any
);

    assign any = |req;

    // Walk the search order backwards so the closest requester after ptr is written last.
    always_comb begin
        win_idx = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (req[j] && (j == ((int'(ptr) + i) % NUM_REQ))) begin
                    win_idx = req_idx_t'(j);
                end
            end
        end
    end

    always_comb begin
        winner = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            winner[j] = any && (win_idx == req_idx_t'(j));
        end
    end

endmodule

// File: rtl/debug_uart_tx_arbiter.sv
// Grants the single OCD UART transmitter to one requester for a whole frame.
// Optional owner-idle timeout: define DEBUG_UART_ARB_TIMEOUT_EN.
module debug_uart_tx_arbiter
    import debug_uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_in,
    input  logic [NUM_REQ-1:0]            tx_start_in,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] tx_data_in,
    input  logic [NUM_REQ-1:0]            frame_done_in,
    output logic [NUM_REQ-1:0]            grant_out,
    output logic [NUM_REQ-1:0]            tx_done_out,
    output logic                          uart_tx_start,
    output logic [DATA_WIDTH-1:0]         uart_tx_data,
    input  logic                          uart_tx_done,
    output logic                          proto_err
);

    state_t                state;
    state_t                state_nxt;
    logic                  pending;
    logic                  pending_nxt;
    req_idx_t              ptr;
    req_idx_t              owner_idx;

    logic [NUM_REQ-1:0]    pick_onehot;
    req_idx_t              pick_idx;
    logic                  pick_any;

    logic                  own_start;
    logic                  own_fd;
    logic                  foreign_start;
    logic                  timeout_hit;
    logic [DATA_WIDTH-1:0] own_data;

    debug_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req     (req_in),
        .ptr     (ptr),
        .winner  (pick_onehot),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    // Ownership is simply the registered grant vector, so masking by it filters non-owners.
    assign own_start     = |(tx_start_in & grant_out);
    assign own_fd        = |(frame_done_in & grant_out);
    assign foreign_start = |(tx_start_in & ~grant_out);

    always_comb begin
        own_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_out[j]) begin
                own_data = tx_data_in[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef DEBUG_UART_ARB_TIMEOUT_EN
    logic [TIMEOUT_CNT_W-1:0] idle_cnt;

    assign timeout_hit = (state == S_OWNED) && !own_start && !own_fd &&
                         (idle_cnt == TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1));

    // Only time spent owning the UART without sending counts as idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt <= '0;
        end else if ((state == S_OWNED) && !own_start && !timeout_hit) begin
            idle_cnt <= idle_cnt + TIMEOUT_CNT_W'(1);
        end else begin
            idle_cnt <= '0;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        unique case (state)
            S_IDLE: begin
                if (pick_any) begin
                    state_nxt = S_OWNED;
                end
            end
            S_OWNED: begin
                // A start takes priority; a coincident frame_done is remembered for later.
                if (own_start) begin
                    state_nxt   = S_BUSY;
                    pending_nxt = own_fd;
                end else if (own_fd || timeout_hit) begin
                    state_nxt = S_RELEASE;
                end
            end
            S_BUSY: begin
                if (uart_tx_done) begin
                    state_nxt   = (pending || own_fd) ? S_RELEASE : S_OWNED;
                    pending_nxt = 1'b0;
                end else if (own_fd) begin
                    pending_nxt = 1'b1;
                end
            end
            S_RELEASE: begin
                state_nxt   = S_IDLE;
                pending_nxt = 1'b0;
            end
            default: begin
                state_nxt   = S_IDLE;
                pending_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            pending       <= 1'b0;
            ptr           <= '0;
            owner_idx     <= '0;
            grant_out     <= '0;
            tx_done_out   <= '0;
            uart_tx_start <= 1'b0;
            uart_tx_data  <= '0;
            proto_err     <= 1'b0;
        end else begin
            state         <= state_nxt;
            pending       <= pending_nxt;
            uart_tx_start <= (state == S_OWNED) && own_start;
            tx_done_out   <= ((state == S_BUSY) && uart_tx_done) ? grant_out : '0;

            if ((state == S_OWNED) && own_start) begin
                uart_tx_data <= own_data;
            end

            if ((state == S_IDLE) && pick_any) begin
                grant_out <= pick_onehot;
                owner_idx <= pick_idx;
            end else if (state == S_RELEASE) begin
                grant_out <= '0;
                ptr       <= owner_idx;
            end

            if (foreign_start || (own_start && (state != S_OWNED)) || timeout_hit) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule
